// File: rtl/ddr_read_arbiter_if.sv
// DDR read port bundle. The arbiter drives it as master; the memory side is the slave.
interface ddr_read_arbiter_if #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 64
);
  logic [AddrWidth-1:0] ddr_address;
  logic                 ddr_r_en;
  logic [DataWidth-1:0] ddr_r_data;
  logic                 ddr_r_valid;

  modport master (output ddr_address, ddr_r_en, input  ddr_r_data, ddr_r_valid);
  modport slave  (input  ddr_address, ddr_r_en, output ddr_r_data, ddr_r_valid);
endinterface

// File: rtl/ddr_read_arbiter.sv
// Round-robin arbiter sharing one DDR read port between NumRequesters clients.
// One read is outstanding at a time; each response is routed to its owner.

// Per-client request slot: holds one pending read and flags duplicate requests.
module ddr_read_arbiter_slot #(
  parameter int AddrWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_en_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 grant_i,
  input  logic                 busy_i,
  output logic                 pending_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic                 drop_o
);
  logic                 pending_q;
  logic [AddrWidth-1:0] addr_q;

  // A request while one is already queued or in flight is dropped.
  assign drop_o    = req_en_i && (pending_q || busy_i);
  assign pending_o = pending_q;
  assign addr_o    = addr_q;

  // Pending flag: set on accepted request, cleared on grant (never both at once).
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                   pending_q <= 1'b0;
    else if (req_en_i && !drop_o)  pending_q <= 1'b1;
    else if (grant_i)              pending_q <= 1'b0;
  end

  // Address latch; only meaningful while pending, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (req_en_i && !drop_o) addr_q <= req_addr_i;
  end
endmodule

module ddr_read_arbiter #(
  parameter int NumRequesters = 2,
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 64
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [NumRequesters-1:0]                req_r_en_i,
  input  logic [NumRequesters-1:0][AddrWidth-1:0] req_address_i,
  output logic [NumRequesters-1:0]                req_r_valid_o,
  output logic [DataWidth-1:0]                    req_r_data_o,
  ddr_read_arbiter_if.master                      ddr,
  output logic                                    protocol_error_o
);
  localparam int PtrW = $clog2(NumRequesters);

  typedef logic [AddrWidth-1:0] ddr_address_t;
  typedef logic [PtrW-1:0]      ptr_t;
  typedef enum logic {IDLE, WAITING} state_e;

  state_e                              state_q, state_d;
  ptr_t                                owner_q, owner_d;
  ptr_t                                rr_ptr_q, rr_ptr_d;
  ptr_t                                gnt_idx;
  logic                                any_pending;
  logic                                err_q;
  logic                                idle_rsp;
  int                                  scan_idx;
  logic [NumRequesters-1:0]            pending_q, grant, busy, drop;
  ddr_address_t [NumRequesters-1:0]    addr_q;

  for (genvar i = 0; i < NumRequesters; i++) begin : g_slot
    // Owner stops being busy in its response cycle, so it may re-request then.
    assign busy[i] = (state_q == WAITING) && (owner_q == ptr_t'(i)) && !ddr.ddr_r_valid;

    ddr_read_arbiter_slot #(.AddrWidth(AddrWidth)) u_slot (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .req_en_i   (req_r_en_i[i]),
      .req_addr_i (req_address_i[i]),
      .grant_i    (grant[i]),
      .busy_i     (busy[i]),
      .pending_o  (pending_q[i]),
      .addr_o     (addr_q[i]),
      .drop_o     (drop[i])
    );
  end

  // Round-robin scan: first registered pending index at or above rr_ptr_q, wrapping.
  always_comb begin
    any_pending = 1'b0;
    gnt_idx     = '0;
    scan_idx    = 0;
    for (int k = 0; k < NumRequesters; k++) begin
      scan_idx = int'(rr_ptr_q) + k;
      if (scan_idx >= NumRequesters) scan_idx = scan_idx - NumRequesters;
      if (!any_pending && pending_q[ptr_t'(scan_idx)]) begin
        any_pending = 1'b1;
        gnt_idx     = ptr_t'(scan_idx);
      end
    end
  end

  // Controller state, owner and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next state and port outputs; outputs held quiet while reset is asserted.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    rr_ptr_d        = rr_ptr_q;
    grant           = '0;
    req_r_valid_o   = '0;
    ddr.ddr_r_en    = 1'b0;
    ddr.ddr_address = addr_q[gnt_idx];
    case (state_q)
      IDLE: begin
        if (any_pending) begin
          grant[gnt_idx] = 1'b1;
          ddr.ddr_r_en   = 1'b1;
          owner_d        = gnt_idx;
          rr_ptr_d       = (gnt_idx == ptr_t'(NumRequesters - 1)) ? '0 : gnt_idx + 1'b1;
          state_d        = WAITING;
        end
      end
      WAITING: begin
        if (ddr.ddr_r_valid) begin
          req_r_valid_o[owner_q] = 1'b1;
          state_d                = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst_ni) begin
      ddr.ddr_r_en  = 1'b0;
      req_r_valid_o = '0;
    end
  end

  assign req_r_data_o = ddr.ddr_r_data;
  assign idle_rsp     = (state_q == IDLE) && ddr.ddr_r_valid;

  // Sticky protocol error: duplicate request or response with nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                   err_q <= 1'b0;
    else if (|drop || idle_rsp)    err_q <= 1'b1;
  end

  assign protocol_error_o = err_q && rst_ni;
endmodule

// File: tb/tb_ddr_read_arbiter.sv
// Scoreboard bench for ddr_read_arbiter (3 clients). Stimulus pushes expected
// issues/responses per client; a negedge monitor pops and compares.
module tb_ddr_read_arbiter;
  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 32;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N-1:0]         req_r_en = '0;
  logic [N-1:0][AW-1:0] req_address = '0;
  logic [N-1:0]         req_r_valid;
  logic [DW-1:0]        req_r_data;
  logic                 protocol_error;

  ddr_read_arbiter_if #(.AddrWidth(AW), .DataWidth(DW)) ddr ();

  ddr_read_arbiter #(.NumRequesters(N), .AddrWidth(AW), .DataWidth(DW)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_r_en_i       (req_r_en),
    .req_address_i    (req_address),
    .req_r_valid_o    (req_r_valid),
    .req_r_data_o     (req_r_data),
    .ddr              (ddr),
    .protocol_error_o (protocol_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic [AW-1:0] exp_iss [N][$];
  logic [DW-1:0] exp_rsp [N][$];
  int grant_log[$];
  int iss_log[$];
  int rsp_log[$];

  // Memory data pattern: low 16 bits are address xor 0x01A5.
  function automatic logic [DW-1:0] mem_data(logic [AW-1:0] a);
    return {16'h0000, a ^ 16'h01A5};
  endfunction

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic bit sb_empty();
    for (int k = 0; k < N; k++)
      if (exp_iss[k].size() != 0 || exp_rsp[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // DDR model: fixed or random latency, plus an injectable stray response.
  int lat = 3;
  bit rand_lat = 1'b0;
  bit inj = 1'b0;
  initial begin : ddr_model
    int cnt;
    logic [AW-1:0] a;
    cnt = 0;
    a = '0;
    ddr.ddr_r_valid = 1'b0;
    ddr.ddr_r_data  = '0;
    forever begin
      @(negedge clk);
      if (ddr.ddr_r_en) begin
        cnt = rand_lat ? int'($urandom_range(5, 1)) : lat;
        a   = ddr.ddr_address;
      end
      @(posedge clk);
      #1;
      ddr.ddr_r_valid = 1'b0;
      if (inj) begin
        ddr.ddr_r_valid = 1'b1;
        ddr.ddr_r_data  = 32'hDEAD_BEEF;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          ddr.ddr_r_valid = 1'b1;
          ddr.ddr_r_data  = mem_data(a);
        end
      end
    end
  end

  // Monitor: every DDR issue and every client response is checked against the queues.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n && ddr.ddr_r_en) begin : issue_chk
        int c;
        c = -1;
        for (int k = 0; k < N; k++)
          if (c < 0 && exp_iss[k].size() > 0 && exp_iss[k][0] == ddr.ddr_address) c = k;
        n_vec++;
        if (c < 0) begin
          n_err++;
          $display("FAIL issue_addr: got %0h, required a queued request address", ddr.ddr_address);
        end else begin
          void'(exp_iss[c].pop_front());
          grant_log.push_back(c);
          iss_log.push_back(cyc);
        end
      end
      if (|req_r_valid) begin : rsp_chk
        int c;
        logic [DW-1:0] e;
        c = -1;
        for (int k = 0; k < N; k++)
          if (req_r_valid == N'(1 << k)) c = k;
        n_vec++;
        if (c < 0) begin
          n_err++;
          $display("FAIL rsp_onehot: got %b, required one-hot", req_r_valid);
        end else if (exp_rsp[c].size() == 0) begin
          n_err++;
          $display("FAIL rsp_unexpected: got pulse on client %0d, required none", c);
        end else begin
          e = exp_rsp[c].pop_front();
          rsp_log.push_back(cyc);
          if (req_r_data !== e) begin
            n_err++;
            $display("FAIL rsp_data c%0d: got %h, required %h", c, req_r_data, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    req_r_en = '0;
  endtask

  task automatic pulse(int c, logic [AW-1:0] a, logic [DW-1:0] d);
    req_r_en[c]    = 1'b1;
    req_address[c] = a;
    exp_iss[c].push_back(a);
    exp_rsp[c].push_back(d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    grant_log.delete();
    iss_log.delete();
    rsp_log.delete();
  endtask

  task automatic wait_done(int budget, string name);
    int t;
    t = 0;
    while (t < budget && !sb_empty()) begin
      tick();
      t++;
    end
    chk({name, "_drain"}, int'(sb_empty()), 1);
    tick();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int t0;
    int rem[N];
    int nxt[N];
    int k1, j0;
    bit busy0, busy1;

    // Reset state
    tick();
    tick();
    chk("rst_ddr_r_en", int'(ddr.ddr_r_en), 0);
    chk("rst_req_r_valid", int'(req_r_valid), 0);
    chk("rst_protocol_error", int'(protocol_error), 0);
    rst_n = 1'b1;
    tick();
    tick();

    // Single read: 0x100 -> data 0xA5, issue t+1, response 3 cycles later
    lat = 3;
    t0 = cyc;
    pulse(0, 16'h0100, 32'h0000_00A5);
    wait_done(50, "single");
    chk("single_issue_cyc", iss_log.size() > 0 ? iss_log[0] : -1, t0 + 1);
    chk("single_rsp_cyc", rsp_log.size() > 0 ? rsp_log[0] : -1, t0 + 4);
    chk("single_no_err", int'(protocol_error), 0);

    // Simultaneous requests from clients 0 and 1
    do_reset();
    pulse(0, 16'h0010, 32'h0000_01B5);
    pulse(1, 16'h0020, 32'h0000_0185);
    wait_done(50, "simul");
    chk("simul_first", grant_log.size() > 0 ? grant_log[0] : -1, 0);
    chk("simul_second", grant_log.size() > 1 ? grant_log[1] : -1, 1);
    chk("simul_gap", iss_log.size() > 1 ? iss_log[1] : -1, (rsp_log.size() > 0 ? rsp_log[0] : -9) + 1);

    // Round-robin: every client re-requests in its own response cycle
    do_reset();
    lat = 2;
    for (int i = 0; i < N; i++) begin
      rem[i] = 2;
      nxt[i] = 1;
      pulse(i, AW'(16'h1000 * (i + 1)), mem_data(AW'(16'h1000 * (i + 1))));
    end
    for (int t = 0; t < 300; t++) begin
      tick();
      for (int i = 0; i < N; i++)
        if (req_r_valid[i] && rem[i] > 0) begin
          pulse(i, AW'(16'h1000 * (i + 1) + nxt[i]), mem_data(AW'(16'h1000 * (i + 1) + nxt[i])));
          rem[i]--;
          nxt[i]++;
        end
      if (sb_empty() && rem[0] == 0 && rem[1] == 0 && rem[2] == 0) break;
    end
    wait_done(50, "rr");
    for (int k = 0; k < 9; k++)
      chk($sformatf("rr_grant%0d", k), grant_log.size() > k ? grant_log[k] : -1, k % 3);
    chk("rr_no_err", int'(protocol_error), 0);

    // Streaming on client1 with sparse client0 reads, random latency
    do_reset();
    rand_lat = 1'b1;
    k1 = 0;
    j0 = 0;
    busy0 = 1'b0;
    busy1 = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      tick();
      if (req_r_valid[1]) busy1 = 1'b0;
      if (req_r_valid[0]) busy0 = 1'b0;
      if (!busy1 && k1 < 16) begin
        pulse(1, AW'(16'h4000 + k1), mem_data(AW'(16'h4000 + k1)));
        busy1 = 1'b1;
        k1++;
      end
      if (!busy0 && j0 < 4 && (cyc % 9) == 0) begin
        pulse(0, AW'(16'h0800 + j0), mem_data(AW'(16'h0800 + j0)));
        busy0 = 1'b1;
        j0++;
      end
      if (k1 == 16 && j0 == 4 && !busy0 && !busy1) break;
    end
    wait_done(50, "stream");
    rand_lat = 1'b0;
    chk("stream_rsp_count", rsp_log.size(), 20);
    chk("stream_no_err", int'(protocol_error), 0);

    // Duplicate request while pending: dropped, error sticky, first request intact
    do_reset();
    lat = 4;
    pulse(1, 16'h0300, 32'h0000_02A5);
    tick();
    tick();
    pulse(0, 16'h0110, 32'h0000_00B5);
    tick();
    chk("dup_err_before", int'(protocol_error), 0);
    req_r_en[0]    = 1'b1;
    req_address[0] = 16'h0120;
    tick();
    chk("dup_err_set", int'(protocol_error), 1);
    wait_done(50, "dup");
    chk("dup_err_sticky", int'(protocol_error), 1);

    // Response while idle
    do_reset();
    chk("stray_err_before", int'(protocol_error), 0);
    inj = 1'b1;
    tick();
    inj = 1'b0;
    chk("stray_no_route", int'(req_r_valid), 0);
    tick();
    chk("stray_err_set", int'(protocol_error), 1);
    pulse(0, 16'h0140, 32'h0000_00E5);
    wait_done(50, "stray");
    chk("stray_err_sticky", int'(protocol_error), 1);

    // Reset while WAITING with client1 pending, then a stale response
    do_reset();
    lat = 6;
    req_r_en[0]    = 1'b1;
    req_address[0] = 16'h0500;
    exp_iss[0].push_back(16'h0500);
    req_r_en[1]    = 1'b1;
    req_address[1] = 16'h0600;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_r_en", int'(ddr.ddr_r_en), 0);
    chk("mid_rst_valid", int'(req_r_valid), 0);
    tick();
    rst_n = 1'b1;
    chk("mid_rst_err", int'(protocol_error), 0);
    chk("mid_rst_iss_drained", int'(sb_empty()), 1);
    tick();
    tick();
    tick();
    chk("stale_no_route", int'(req_r_valid), 0);
    tick();
    chk("stale_err_set", int'(protocol_error), 1);
    pulse(1, 16'h0600, 32'h0000_07A5);
    wait_done(50, "after_rst");
    chk("after_rst_err_sticky", int'(protocol_error), 1);

    repeat (5) tick();
    chk("final_sb_empty", int'(sb_empty()), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ddr_read_arbiter.md
# ddr_read_arbiter

Shares the single DDR read port between `NumRequesters` read clients, such as the ternary matmul matrix stream and future weight/activation loaders. Each client keeps the existing single-cycle `r_en` pulse / later `r_valid` protocol and sees the arbiter as a private DDR port. The arbiter latches every request in the cycle it is pulsed and forwards requests to DDR one at a time, in round-robin order. Each DDR response is routed back to the client that owns the outstanding read.

## Interface
Parameters:
- `NumRequesters`, default 2: number of read clients; legal range 2..8.

Ports:
- `clk_i` in 1: the single clock.
- `rst_ni` in 1: synchronous, active-low reset.
- `req_r_en_i` in `[NumRequesters]`: per-client one-cycle read request pulse.
- `req_address_i` in `ddr_address_t [NumRequesters]`: per-client read address; valid only when the matching `req_r_en_i` is high.
- `req_r_valid_o` out `[NumRequesters]`: one-cycle response pulse to the owning client.
- `req_r_data_o` out `ddr_data_t`: response data, broadcast to all clients; meaningful only with `req_r_valid_o`.
- `ddr_address_o` out `ddr_address_t`: DDR read address; don't-care when `ddr_r_en_o` is low.
- `ddr_r_en_o` out 1: DDR read request pulse.
- `ddr_r_data_i` in `ddr_data_t`: DDR read data.
- `ddr_r_valid_i` in 1: DDR read data valid.
- `protocol_error_o` out 1: sticky flag for a protocol violation; cleared only by reset.

## Operation
Per-client registers:
- `pending_q[i]`: a request is waiting to be issued.
- `addr_q[i]`: the latched address.

Controller registers:
- `state_q`: IDLE or WAITING.
- `owner_q`: index of the client whose read is outstanding.
- `rr_ptr_q`: round-robin pointer, `$clog2(NumRequesters)` bits.

Request capture:
- When `req_r_en_i[i]=1`, set `pending_q[i]` and `addr_q[i] <= req_address_i[i]`.
- All clients may request in the same cycle.
- If client i requests while `pending_q[i]` is set, or while it owns the outstanding read, the request is dropped, `protocol_error_o` is set, and the stored state is unchanged.

IDLE state:
- If any `pending_q` bit is set, grant g = the first index with a pending request, scanning upward from `rr_ptr_q` with wrap-around.
- Drive `ddr_r_en_o=1` and `ddr_address_o=addr_q[g]`.
- Clear `pending_q[g]`, set `owner_q<=g` and `rr_ptr_q<=(g+1) mod NumRequesters`, then go to WAITING.
- Grant logic uses registered `pending_q` only, so a request pulsed in the current cycle is not grantable until the next cycle.

WAITING state:
- `ddr_r_en_o=0`.
- On `ddr_r_valid_i`: `req_r_valid_o[owner_q]=1`, `req_r_data_o=ddr_r_data_i` (combinational passthrough), then go to IDLE.

Error cases:
- `ddr_r_valid_i` while IDLE: the response is dropped and `protocol_error_o` is set.

Reset:
- While `rst_ni=0` at a clock edge: `pending_q` and `state_q=IDLE`, `rr_ptr_q=0`, `protocol_error_o=0`.
- Reset mid-operation discards all pending and outstanding reads.
- A stale DDR response arriving after reset counts as a valid-while-IDLE error.

## Timing
Output values in reset and when idle:
- `ddr_r_en_o=0`, `req_r_valid_o='0`, `protocol_error_o=0`.
- `req_r_data_o` and `ddr_address_o` are don't-care.

Latency and throughput:
- A request pulsed at cycle t into an idle arbiter with nothing else pending issues `ddr_r_en_o` at t+1.
- A DDR response at cycle u produces `req_r_valid_o` at u, with zero added latency.
- The next grant issues no earlier than u+1, so the DDR port carries at most one outstanding read.
- Back-to-back throughput is one read per (DDR latency + 1) cycles.

Simultaneous events:
- A request from client i in the same cycle its response is delivered is accepted normally and is not an error.
- A capture and a grant of the same client cannot coincide, because grants use only registered `pending_q`.

Fairness:
- With all clients continuously requesting, grants rotate 0,1,...,N-1,0.
- No client waits more than N-1 grants.

## Test plan
- **Single read:** reset; client0 pulses at cycle 5 with address 0x100; DDR returns data 0xA5 three cycles after request → `ddr_r_en_o` at cycle 6 with address 0x100; `req_r_valid_o=2'b01` with data 0xA5 at cycle 9; no other pulses.
- **Simultaneous requests (N=2):** both clients pulse at the same cycle with addresses 0x10 and 0x20 → DDR sees 0x10 then 0x20; responses route to client0 then client1; the second issue comes exactly one cycle after the first response.
- **Round-robin:** N=3; all clients re-request immediately after each response, for 9 reads → grant order is 0,1,2,0,1,2,0,1,2.
- **Matmul-style streaming:** client1 issues 16 sequential reads (address base+k) against random DDR latency of 1-5 cycles, while client0 issues sparse reads → every response reaches its correct owner with correct data; no errors.
- **Protocol errors:** client0 pulses twice before being granted; separately, inject `ddr_r_valid_i` while idle → `protocol_error_o` rises and stays high; the first request still completes normally.
- **Reset mid-operation:** reset while WAITING with client1 pending → after reset all outputs are 0 and no `req_r_valid_o` occurs; a late `ddr_r_valid_i` sets `protocol_error_o`; a new client1 request then completes normally.
